// File: rtl/pipe_stage_reg_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_if
// Valid/ready handshake bundle for one side of a pipeline boundary register.
//   valid : producer has an entry
//   ready : consumer can take it this cycle
//   ctrl  : control bundle (WB+M+EX), CTRL_W bits
//   data  : data bundle (operands, immediate, reg addresses, PC), DATA_W bits
// master = producer side, slave = consumer side.
// ---------------------------------------------------------------------------
interface pipe_stage_reg_if #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 143
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input ready);
    modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Generic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Control bundle is zeroed on flush; data bundle holds its value.
// SKID=0 : single entry, combinational in_ready.
// SKID=1 : 2-entry skid buffer, in_ready driven from a flop.
//
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   flush     : synchronous bubble insert, empties the stage
//   in_if     : upstream handshake (slave)  valid/ready/ctrl/data
//   out_if    : downstream handshake (master) valid/ready/ctrl/data
//   occupancy : number of entries held (0..2)
//
// Skid FSM (SKID=1):
//   state   | meaning
//   S_EMPTY | no entry held, occupancy 0
//   S_ONE   | main entry valid, occupancy 1
//   S_TWO   | main and skid entries valid, occupancy 2, in_ready low
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 143,
    parameter int SKID   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    pipe_stage_reg_if.slave         in_if,
    pipe_stage_reg_if.master        out_if,
    output logic [1:0]              occupancy
);

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              drain;

    assign drain        = main_valid & out_if.ready;
    assign out_if.valid = main_valid;
    // Downstream must always see a NOP bubble when nothing is valid.
    assign out_if.ctrl  = main_valid ? main_ctrl : '0;
    assign out_if.data  = main_data;

    if (SKID == 0) begin : g_single
        logic accept;

        assign in_if.ready = ~main_valid | out_if.ready;
        assign accept      = in_if.valid & in_if.ready;
        assign occupancy   = {1'b0, main_valid};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                main_valid <= 1'b0;
                main_ctrl  <= '0;
                main_data  <= '0;
            end else if (flush) begin
                main_valid <= 1'b0;
                main_ctrl  <= '0;
            end else if (accept) begin
                // Covers drain+accept too: entry is replaced with no bubble.
                main_valid <= 1'b1;
                main_ctrl  <= in_if.ctrl;
                main_data  <= in_if.data;
            end else if (drain) begin
                main_valid <= 1'b0;
            end
        end
    end else begin : g_skid
        typedef enum logic [1:0] {
            S_EMPTY = 2'd0,
            S_ONE   = 2'd1,
            S_TWO   = 2'd2
        } state_t;

        state_t            state_q;
        state_t            state_d;
        logic              rdy_q;
        logic              accept;
        logic              load_main;
        logic              load_skid;
        logic              shift;
        logic [CTRL_W-1:0] skid_ctrl;
        logic [DATA_W-1:0] skid_data;

        assign in_if.ready = rdy_q;
        assign accept      = in_if.valid & rdy_q;
        assign main_valid  = (state_q != S_EMPTY);
        assign occupancy   = (state_q == S_TWO) ? 2'd2 :
                             (state_q == S_ONE) ? 2'd1 : 2'd0;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= S_EMPTY;
                rdy_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                // Registered backward ready: low exactly when the next state is full.
                rdy_q   <= (state_d != S_TWO);
            end
        end

        always_comb begin
            state_d   = state_q;
            load_main = 1'b0;
            load_skid = 1'b0;
            shift     = 1'b0;
            if (flush) begin
                state_d = S_EMPTY;
            end else begin
                case (state_q)
                    S_EMPTY: begin
                        if (accept) begin
                            load_main = 1'b1;
                            state_d   = S_ONE;
                        end
                    end
                    S_ONE: begin
                        if (accept && drain) begin
                            load_main = 1'b1;
                        end else if (accept) begin
                            load_skid = 1'b1;
                            state_d   = S_TWO;
                        end else if (drain) begin
                            state_d   = S_EMPTY;
                        end
                    end
                    S_TWO: begin
                        if (drain) begin
                            shift   = 1'b1;
                            state_d = S_ONE;
                        end
                    end
                    default: state_d = S_EMPTY;
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                main_ctrl <= '0;
                main_data <= '0;
                skid_ctrl <= '0;
                skid_data <= '0;
            end else if (flush) begin
                main_ctrl <= '0;
                skid_ctrl <= '0;
            end else begin
                if (load_main) begin
                    main_ctrl <= in_if.ctrl;
                    main_data <= in_if.data;
                end else if (shift) begin
                    main_ctrl <= skid_ctrl;
                    main_data <= skid_data;
                    skid_ctrl <= '0;
                end
                if (load_skid) begin
                    skid_ctrl <= in_if.ctrl;
                    skid_data <= in_if.data;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
// Drives one SKID=0 and one SKID=1 instance: directed vector tables,
// an asynchronous-reset sequence and a random valid/ready/flush run
// checked against a queue scoreboard.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int CW = 9;
    localparam int DW = 143;

    logic clk;
    logic rst_n;

    logic [1:0]    iv;
    logic [1:0]    ordy;
    logic [1:0]    fl;
    logic [CW-1:0] ic [2];
    logic [DW-1:0] id [2];

    wire           ir_w [2];
    wire           ov_w [2];
    wire [CW-1:0]  oc   [2];
    wire [DW-1:0]  od   [2];
    wire [1:0]     occ  [2];

    int total = 0;
    int bad   = 0;

    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) up0 ();
    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) dn0 ();
    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) up1 ();
    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) dn1 ();

    assign up0.valid = iv[0];
    assign up0.ctrl  = ic[0];
    assign up0.data  = id[0];
    assign dn0.ready = ordy[0];
    assign up1.valid = iv[1];
    assign up1.ctrl  = ic[1];
    assign up1.data  = id[1];
    assign dn1.ready = ordy[1];

    assign ir_w[0] = up0.ready;
    assign ov_w[0] = dn0.valid;
    assign oc[0]   = dn0.ctrl;
    assign od[0]   = dn0.data;
    assign ir_w[1] = up1.ready;
    assign ov_w[1] = dn1.valid;
    assign oc[1]   = dn1.ctrl;
    assign od[1]   = dn1.data;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (fl[0]),
        .in_if     (up0.slave),
        .out_if    (dn0.master),
        .occupancy (occ[0])
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (fl[1]),
        .in_if     (up1.slave),
        .out_if    (dn1.master),
        .occupancy (occ[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int            s;
        logic          iv;
        logic [CW-1:0] ic;
        logic [15:0]   id;
        logic          ordy;
        logic          fl;
        logic          e_ir;
        logic          e_ov;
        logic [CW-1:0] e_oc;
        logic [15:0]   e_od;
        logic [1:0]    e_occ;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int s, logic v, logic [CW-1:0] c, logic [15:0] d,
                                logic r, logic f, logic e_ir, logic e_ov,
                                logic [CW-1:0] e_oc, logic [15:0] e_od, logic [1:0] e_occ);
        vec_t t;
        t.s = s; t.iv = v; t.ic = c; t.id = d; t.ordy = r; t.fl = f;
        t.e_ir = e_ir; t.e_ov = e_ov; t.e_oc = e_oc; t.e_od = e_od; t.e_occ = e_occ;
        return t;
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_all();
        iv   = '0;
        ordy = '0;
        fl   = '0;
    endtask

    task automatic apply(input int n, input vec_t v);
        int s;
        s = v.s;
        @(negedge clk);
        idle_all();
        iv[s]   = v.iv;
        ic[s]   = v.ic;
        id[s]   = DW'(v.id);
        ordy[s] = v.ordy;
        fl[s]   = v.fl;
        #1;
        check($sformatf("v%0d_s%0d_in_ready", n, s), 160'(ir_w[s]), 160'(v.e_ir));
        @(posedge clk);
        #1;
        check($sformatf("v%0d_s%0d_out_valid", n, s), 160'(ov_w[s]), 160'(v.e_ov));
        check($sformatf("v%0d_s%0d_out_ctrl", n, s), 160'(oc[s]), 160'(v.e_oc));
        check($sformatf("v%0d_s%0d_out_data", n, s), 160'(od[s]), 160'(DW'(v.e_od)));
        check($sformatf("v%0d_s%0d_occupancy", n, s), 160'(occ[s]), 160'(v.e_occ));
    endtask

    logic [CW+DW-1:0] sbm [2][2048];
    int               wr  [2];
    int               rd  [2];

    initial begin
        idle_all();
        ic[0] = '0; ic[1] = '0; id[0] = '0; id[1] = '0;
        rst_n = 1'b0;

        // reset state
        #2;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_s%0d_out_valid", d), 160'(ov_w[d]), 160'(0));
            check($sformatf("rst_s%0d_out_ctrl", d), 160'(oc[d]), 160'(0));
            check($sformatf("rst_s%0d_out_data", d), 160'(od[d]), 160'(0));
            check($sformatf("rst_s%0d_occupancy", d), 160'(occ[d]), 160'(0));
        end
        check("rst_s1_in_ready_low", 160'(ir_w[1]), 160'(0));
        #18;
        rst_n = 1'b1;
        #1;
        check("rst_release_s1_in_ready_before_edge", 160'(ir_w[1]), 160'(0));
        @(posedge clk);
        #1;
        check("rst_release_s1_in_ready_after_edge", 160'(ir_w[1]), 160'(1));
        repeat (2) @(posedge clk);

        // SKID=0: basic transfer and back-to-back stream
        tbl.push_back(mk(0, 1, 9'h1A5, 16'h1234, 1, 0,  1, 1, 9'h1A5, 16'h1234, 1));
        tbl.push_back(mk(0, 1, 9'h011, 16'h0011, 1, 0,  1, 1, 9'h011, 16'h0011, 1));
        tbl.push_back(mk(0, 1, 9'h012, 16'h0012, 1, 0,  1, 1, 9'h012, 16'h0012, 1));
        tbl.push_back(mk(0, 1, 9'h013, 16'h0013, 1, 0,  1, 1, 9'h013, 16'h0013, 1));
        tbl.push_back(mk(0, 1, 9'h014, 16'h0014, 1, 0,  1, 1, 9'h014, 16'h0014, 1));
        tbl.push_back(mk(0, 1, 9'h015, 16'h0015, 1, 0,  1, 1, 9'h015, 16'h0015, 1));
        tbl.push_back(mk(0, 0, 9'h000, 16'h0000, 1, 0,  1, 0, 9'h000, 16'h0015, 0));
        // SKID=0: stall three cycles, then release
        tbl.push_back(mk(0, 1, 9'h021, 16'h0021, 0, 0,  1, 1, 9'h021, 16'h0021, 1));
        tbl.push_back(mk(0, 1, 9'h022, 16'h0022, 0, 0,  0, 1, 9'h021, 16'h0021, 1));
        tbl.push_back(mk(0, 1, 9'h022, 16'h0022, 0, 0,  0, 1, 9'h021, 16'h0021, 1));
        tbl.push_back(mk(0, 1, 9'h022, 16'h0022, 0, 0,  0, 1, 9'h021, 16'h0021, 1));
        tbl.push_back(mk(0, 1, 9'h022, 16'h0022, 1, 0,  1, 1, 9'h022, 16'h0022, 1));
        tbl.push_back(mk(0, 0, 9'h000, 16'h0000, 1, 0,  1, 0, 9'h000, 16'h0022, 0));
        // SKID=0: flush with input in flight; data keeps last value
        tbl.push_back(mk(0, 1, 9'h031, 16'h0031, 0, 0,  1, 1, 9'h031, 16'h0031, 1));
        tbl.push_back(mk(0, 1, 9'h032, 16'h0032, 0, 1,  0, 0, 9'h000, 16'h0031, 0));
        tbl.push_back(mk(0, 0, 9'h000, 16'h0000, 0, 0,  1, 0, 9'h000, 16'h0031, 0));
        // SKID=1: fill to two, drain in FIFO order
        tbl.push_back(mk(1, 1, 9'h001, 16'h0001, 0, 0,  1, 1, 9'h001, 16'h0001, 1));
        tbl.push_back(mk(1, 1, 9'h002, 16'h0002, 0, 0,  1, 1, 9'h001, 16'h0001, 2));
        tbl.push_back(mk(1, 1, 9'h003, 16'h0003, 0, 0,  0, 1, 9'h001, 16'h0001, 2));
        tbl.push_back(mk(1, 0, 9'h000, 16'h0000, 1, 0,  0, 1, 9'h002, 16'h0002, 1));
        tbl.push_back(mk(1, 0, 9'h000, 16'h0000, 1, 0,  1, 0, 9'h000, 16'h0002, 0));
        // SKID=1: reload in ONE, go to TWO, drain back while input waits
        tbl.push_back(mk(1, 1, 9'h004, 16'h0004, 1, 0,  1, 1, 9'h004, 16'h0004, 1));
        tbl.push_back(mk(1, 1, 9'h005, 16'h0005, 1, 0,  1, 1, 9'h005, 16'h0005, 1));
        tbl.push_back(mk(1, 1, 9'h006, 16'h0006, 0, 0,  1, 1, 9'h005, 16'h0005, 2));
        tbl.push_back(mk(1, 1, 9'h007, 16'h0007, 1, 0,  0, 1, 9'h006, 16'h0006, 1));
        tbl.push_back(mk(1, 1, 9'h007, 16'h0007, 1, 0,  1, 1, 9'h007, 16'h0007, 1));
        tbl.push_back(mk(1, 0, 9'h000, 16'h0000, 1, 0,  1, 0, 9'h000, 16'h0007, 0));
        // SKID=1: flush from TWO with input in flight
        tbl.push_back(mk(1, 1, 9'h0A1, 16'h00AB, 0, 0,  1, 1, 9'h0A1, 16'h00AB, 1));
        tbl.push_back(mk(1, 1, 9'h0A2, 16'h00AB, 0, 0,  1, 1, 9'h0A1, 16'h00AB, 2));
        tbl.push_back(mk(1, 1, 9'h0A3, 16'h00CD, 1, 1,  0, 0, 9'h000, 16'h00AB, 0));
        tbl.push_back(mk(1, 0, 9'h000, 16'h0000, 0, 0,  1, 0, 9'h000, 16'h00AB, 0));

        foreach (tbl[i]) apply(i, tbl[i]);

        // Asynchronous reset while both stages stall with one entry
        @(negedge clk);
        idle_all();
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b1;
            ic[d] = 9'h155;
            id[d] = DW'(16'h7777);
        end
        @(posedge clk);
        #1;
        iv = '0;
        for (int d = 0; d < 2; d++)
            check($sformatf("areset_pre_s%0d_occupancy", d), 160'(occ[d]), 160'(1));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("areset_s%0d_out_valid", d), 160'(ov_w[d]), 160'(0));
            check($sformatf("areset_s%0d_out_ctrl", d), 160'(oc[d]), 160'(0));
            check($sformatf("areset_s%0d_out_data", d), 160'(od[d]), 160'(0));
            check($sformatf("areset_s%0d_occupancy", d), 160'(occ[d]), 160'(0));
        end
        check("areset_s1_in_ready", 160'(ir_w[1]), 160'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Random valid/ready/flush against a FIFO scoreboard, both variants
        wr[0] = 0; wr[1] = 0; rd[0] = 0; rd[1] = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                iv[d]   = ($urandom_range(0, 99) < 60);
                ordy[d] = ($urandom_range(0, 99) < 60);
                fl[d]   = ($urandom_range(0, 99) < 3);
                ic[d]   = CW'($urandom_range(0, 511));
                id[d]   = {15'h0, $urandom, $urandom, $urandom, $urandom};
            end
            #2;
            for (int d = 0; d < 2; d++) begin
                int  size;
                logic exp_ir;
                logic drn;
                logic acc;
                size   = wr[d] - rd[d];
                exp_ir = (d == 0) ? ((size == 0) || ordy[d]) : (size != 2);
                check($sformatf("rnd%0d_s%0d_occupancy", cyc, d), 160'(occ[d]), 160'(size));
                check($sformatf("rnd%0d_s%0d_out_valid", cyc, d), 160'(ov_w[d]), 160'(size != 0));
                check($sformatf("rnd%0d_s%0d_in_ready", cyc, d), 160'(ir_w[d]), 160'(exp_ir));
                if (size == 0)
                    check($sformatf("rnd%0d_s%0d_bubble_ctrl", cyc, d), 160'(oc[d]), 160'(0));
                else
                    check($sformatf("rnd%0d_s%0d_head", cyc, d), 160'({oc[d], od[d]}), 160'(sbm[d][rd[d]]));
                drn = (size != 0) && ordy[d];
                acc = iv[d] && exp_ir;
                if (fl[d]) begin
                    rd[d] = wr[d];
                end else begin
                    if (drn) rd[d] = rd[d] + 1;
                    if (acc) begin
                        sbm[d][wr[d]] = {ic[d], id[d]};
                        wr[d] = wr[d] + 1;
                    end
                end
            end
        end

        @(negedge clk);
        idle_all();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic parametrised pipeline-boundary register that replaces the hand-written inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control bundle, which is zeroed on flush, and a data bundle, which holds its value on flush.
- Adds a valid/ready handshake for stalls and an optional 2-entry skid buffer that registers the backward ready path.
- Sits between any two CPU pipeline stages. The hazard unit drives flush.

Parameters:
- CTRL_W, 9: width of the control bundle (WB+M+EX); zeroed on flush/reset.
- DATA_W, 143: width of the data bundle (operands, immediate, register addresses, PC); never zeroed by flush.
- SKID, 0: 0 = single register with combinational ready; 1 = 2-entry skid buffer with registered in_ready.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous bubble insert; empties the stage.
- in_valid  in  1  upstream has a valid entry.
- in_ready  out  1  stage can accept this cycle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts the head.
- out_ctrl  out  CTRL_W  head control; forced to 0 whenever out_valid=0.
- out_data  out  DATA_W  head data.
- occupancy  out  2  number of entries held (0..1 for SKID=0, 0..2 for SKID=1).

Behaviour:
- Transfers: an accept is in_valid & in_ready at a rising edge; a drain is out_valid & out_ready at a rising edge.
- Reset (rst_n=0, asynchronous): all valid bits 0, all ctrl and data registers 0, occupancy 0, out_valid 0, out_ctrl 0, out_data 0. For SKID=1, in_ready=0 while rst_n=0 and 1 from the first edge after release.
- SKID=0:
  - Single entry. in_ready = ~out_valid | out_ready (combinational).
  - Accept → next cycle out_valid=1, out_ctrl/out_data = the captured values. Latency is 1 cycle.
  - Drain with no accept → out_valid=0.
  - Drain and accept in the same cycle → the entry is replaced; there is no bubble.
  - Stall (out_ready=0 with entry held): contents hold.
- SKID=1:
  - States are EMPTY (occ 0), ONE (main valid), TWO (main and skid valid). in_ready = (state != TWO), driven from a register.
  - EMPTY: accept → ONE.
  - ONE: accept & drain → ONE (main reloads). Accept without drain → TWO (input goes to skid). Drain without accept → EMPTY.
  - TWO: drain → ONE (skid moves to main). No accept is possible.
  - Ordering is strictly FIFO.
- Flush (synchronous, highest priority):
  - Clears all valid bits and all ctrl registers, so occupancy becomes 0 on the next edge.
  - Any same-cycle accept is discarded, and in_ready's value that cycle does not matter.
  - A same-cycle drain still completes on the downstream side; the stage just empties.
  - Data registers keep their previous values.
- Output gating: out_ctrl = 0 whenever out_valid=0, so downstream always sees a NOP bubble.
- Widths: no arithmetic. occupancy is exact and never exceeds 2. Accepting in state TWO is impossible because in_ready=0 there.
- Reset asserted mid-operation: immediate clear regardless of clk, with all reset values as above.

Test Plan:
1. SKID=0, reset then release; in_valid=1, in_ctrl=9'h1A5, in_data=143'h1234, out_ready=1 → next cycle out_valid=1, out_ctrl=9'h1A5, out_data=143'h1234, occupancy=1. A back-to-back stream of 5 entries emerges in order with no bubbles.
2. SKID=0 stall: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and the output stays at the first entry. Raise out_ready → the next entry appears one cycle later and none are lost or duplicated.
3. SKID=1: out_ready=0 with 2 accepts (ctrl 9'h001, 9'h002) → occupancy=2, in_ready=0. Set out_ready=1 → 9'h001 then 9'h002 drain on consecutive cycles, occupancy 2→1→0.
4. Flush: occupancy=2 (SKID=1) with data 143'hAB held; assert flush while in_valid=1 → next cycle occupancy=0, out_valid=0, out_ctrl=0, internal data regs still 143'hAB, and the in-flight input is not stored.
5. Async reset mid-stall: occupancy=1, drop rst_n between clock edges → out_valid, out_ctrl, out_data and occupancy read 0 immediately, before the next clk edge.
6. Randomised valid/ready (1000 cycles, both SKID values) → the scoreboard shows the output sequence equals the accepted sequence excluding flushed entries, and out_ctrl=0 on every cycle where out_valid=0.
